// File: rtl/wave_scaler.sv
`default_nettype none
// ============================================================================
//  Module   : wave_scaler
//  Purpose  : DDS output stage. Selects sine/ramp/square/DC, applies signed
//             gain and offset with saturation, and drives the DAC bus.
//             Optional sticky clip flag: WAVE_SCALER_CLIP_FLAG_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module wave_scaler #(
    parameter int DAT_W  = 14,
    parameter int GAIN_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DAT_W-1:0]  sine_din,
    input  logic [DAT_W-1:0]  ramp_din,
    input  logic              phase_msb,
    input  logic              cfg_wr,
    input  logic              cfg_imm,
    input  logic [1:0]        cfg_wave_sel,
    input  logic [GAIN_W-1:0] cfg_gain,
    input  logic [DAT_W-1:0]  cfg_offset,
    output logic              cfg_pending,
    output logic [DAT_W-1:0]  dac_dout,
    output logic              dout_valid
`ifdef WAVE_SCALER_CLIP_FLAG_EN
    ,
    input  logic              clip_clr,
    output logic              clip_sticky
`endif
);

    localparam int                c_PW    = DAT_W + GAIN_W + 1;
    localparam logic [DAT_W-1:0]  c_MID   = {1'b1, {(DAT_W-1){1'b0}}};
    localparam logic [GAIN_W-1:0] c_UNITY = {1'b1, {(GAIN_W-1){1'b0}}};
    localparam logic signed [c_PW-1:0] c_SAT_MAX = {{(c_PW-DAT_W+1){1'b0}}, {(DAT_W-1){1'b1}}};
    localparam logic signed [c_PW-1:0] c_SAT_MIN = {{(c_PW-DAT_W+1){1'b1}}, {(DAT_W-1){1'b0}}};

    // ---------------- configuration shadowing ----------------
    logic [1:0]        r_act_sel,  r_pend_sel;
    logic [GAIN_W-1:0] r_act_gain, r_pend_gain;
    logic [DAT_W-1:0]  r_act_off,  r_pend_off;
    logic              r_pending;
    logic              r_imm_due;
    logic              r_prev_msb;
    logic              w_wrap;
    logic              w_apply;

    assign w_wrap  = en & r_prev_msb & ~phase_msb;
    // An immediate request always wins; otherwise apply only on a wrap.
    assign w_apply = r_imm_due | (w_wrap & r_pending);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_sel   <= 2'd0;
            r_act_gain  <= c_UNITY;
            r_act_off   <= '0;
            r_pend_sel  <= 2'd0;
            r_pend_gain <= c_UNITY;
            r_pend_off  <= '0;
            r_pending   <= 1'b0;
            r_imm_due   <= 1'b0;
            r_prev_msb  <= 1'b0;
        end else begin
            if (w_apply) begin
                r_act_sel  <= r_pend_sel;
                r_act_gain <= r_pend_gain;
                r_act_off  <= r_pend_off;
            end
            if (cfg_wr) begin
                r_pend_sel  <= cfg_wave_sel;
                r_pend_gain <= cfg_gain;
                r_pend_off  <= cfg_offset;
                r_pending   <= 1'b1;
                r_imm_due   <= cfg_imm;
            end else if (w_apply) begin
                r_pending <= 1'b0;
                r_imm_due <= 1'b0;
            end
            if (en) begin
                r_prev_msb <= phase_msb;
            end
        end
    end

    assign cfg_pending = r_pending;

    // ---------------- S1: select and convert to signed ----------------
    logic [DAT_W-1:0] w_raw;
    logic [DAT_W-1:0] w_s1_samp;

    always_comb begin
        w_raw = sine_din;
        case (r_act_sel)
            2'd0:    w_raw = sine_din;
            2'd1:    w_raw = ramp_din;
            2'd2:    w_raw = phase_msb ? {DAT_W{1'b1}} : {DAT_W{1'b0}};
            default: w_raw = c_MID;
        endcase
    end

    assign w_s1_samp = {~w_raw[DAT_W-1], w_raw[DAT_W-2:0]};

    logic [DAT_W-1:0]  r_s1_samp;
    logic [GAIN_W-1:0] r_s1_gain;
    logic [DAT_W-1:0]  r_s1_off;

    // ---------------- S2: multiply and rescale ----------------
    logic [c_PW-1:0]        w_samp_ext;
    logic [c_PW-1:0]        w_gain_ext;
    logic signed [c_PW-1:0] w_prod;
    logic signed [c_PW-1:0] w_scaled;

    assign w_samp_ext = {{(c_PW-DAT_W){r_s1_samp[DAT_W-1]}}, r_s1_samp};
    assign w_gain_ext = {{(c_PW-GAIN_W){1'b0}}, r_s1_gain};
    assign w_prod     = $signed(w_samp_ext) * $signed(w_gain_ext);
    assign w_scaled   = w_prod >>> (GAIN_W - 1);

    logic signed [c_PW-1:0] r_s2_scaled;
    logic [DAT_W-1:0]       r_s2_off;

    // ---------------- S3: offset and saturate ----------------
    logic signed [c_PW-1:0] w_off_ext;
    logic signed [c_PW-1:0] w_sum;
    logic                   w_hi;
    logic                   w_lo;
    logic [DAT_W-1:0]       w_sat;

    assign w_off_ext = $signed({{(c_PW-DAT_W){r_s2_off[DAT_W-1]}}, r_s2_off});
    assign w_sum     = r_s2_scaled + w_off_ext;
    assign w_hi      = (w_sum > c_SAT_MAX);
    assign w_lo      = (w_sum < c_SAT_MIN);

    always_comb begin
        w_sat = w_sum[DAT_W-1:0];
        if (w_hi) begin
            w_sat = {1'b0, {(DAT_W-1){1'b1}}};
        end else if (w_lo) begin
            w_sat = {1'b1, {(DAT_W-1){1'b0}}};
        end
    end

    logic [DAT_W-1:0] r_dac;
    logic [1:0]       r_fill;

    // Stage registers reset to a midscale sample at unity gain so the
    // bus reads midscale while the pipeline fills.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_samp   <= '0;
            r_s1_gain   <= c_UNITY;
            r_s1_off    <= '0;
            r_s2_scaled <= '0;
            r_s2_off    <= '0;
            r_dac       <= c_MID;
            r_fill      <= 2'd0;
        end else if (en) begin
            r_s1_samp   <= w_s1_samp;
            r_s1_gain   <= r_act_gain;
            r_s1_off    <= r_act_off;
            r_s2_scaled <= w_scaled;
            r_s2_off    <= r_s1_off;
            r_dac       <= {~w_sat[DAT_W-1], w_sat[DAT_W-2:0]};
            if (r_fill != 2'd3) begin
                r_fill <= r_fill + 2'd1;
            end
        end
    end

    assign dac_dout   = r_dac;
    assign dout_valid = (r_fill == 2'd3);

`ifdef WAVE_SCALER_CLIP_FLAG_EN
    logic r_clip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clip <= 1'b0;
        end else if (en && (w_hi || w_lo)) begin
            r_clip <= 1'b1;
        end else if (clip_clr) begin
            r_clip <= 1'b0;
        end
    end

    assign clip_sticky = r_clip;
`else
    // Clip detection is not built; the clamp alone shapes the output.
`endif

endmodule
`default_nettype wire

// File: tb/tb_wave_scaler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wave_scaler
//  Purpose  : Self-checking bench for wave_scaler with a queue scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wave_scaler;

    localparam int DW = 14;
    localparam int GW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [DW-1:0] sine_din;
    logic [DW-1:0] ramp_din;
    logic          phase_msb;
    logic          cfg_wr;
    logic          cfg_imm;
    logic [1:0]    cfg_wave_sel;
    logic [GW-1:0] cfg_gain;
    logic [DW-1:0] cfg_offset;
    logic          cfg_pending;
    logic [DW-1:0] dac_dout;
    logic          dout_valid;
    logic          clip_clr;
`ifdef WAVE_SCALER_CLIP_FLAG_EN
    logic          clip_sticky;
`endif

    always #5 clk = ~clk;

    wave_scaler #(.DAT_W(DW), .GAIN_W(GW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .sine_din     (sine_din),
        .ramp_din     (ramp_din),
        .phase_msb    (phase_msb),
        .cfg_wr       (cfg_wr),
        .cfg_imm      (cfg_imm),
        .cfg_wave_sel (cfg_wave_sel),
        .cfg_gain     (cfg_gain),
        .cfg_offset   (cfg_offset),
        .cfg_pending  (cfg_pending),
        .dac_dout     (dac_dout),
        .dout_valid   (dout_valid)
`ifdef WAVE_SCALER_CLIP_FLAG_EN
        ,
        .clip_clr     (clip_clr),
        .clip_sticky  (clip_sticky)
`endif
    );

    typedef struct {
        logic [DW-1:0] val;
        bit            clip;
    } exp_t;

    exp_t q[$];

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [1:0]    m_sel, p_sel;
    logic [GW-1:0] m_gain, p_gain;
    logic [DW-1:0] m_off, p_off;
    bit            m_pending, m_imm_due, m_prev, m_clip;
    int            m_fill;
    logic [DW-1:0] m_dac;

    function automatic exp_t calc(input logic [1:0] sel, input logic [GW-1:0] g,
                                  input logic [DW-1:0] off, input logic [DW-1:0] s,
                                  input logic [DW-1:0] r, input logic m);
        exp_t   e;
        longint raw, gl, os, p, sum;
        case (sel)
            2'd0:    raw = s;
            2'd1:    raw = r;
            2'd2:    raw = m ? 16383 : 0;
            default: raw = 8192;
        endcase
        gl  = g;
        os  = off;
        if (off[DW-1]) os = os - 16384;
        p   = (raw - 8192) * gl;
        p   = p >>> 15;
        sum = p + os;
        e.clip = 1'b0;
        if (sum > 8191) begin
            sum = 8191;
            e.clip = 1'b1;
        end else if (sum < -8192) begin
            sum = -8192;
            e.clip = 1'b1;
        end
        e.val = DW'(sum + 8192);
        return e;
    endfunction

    task automatic model_reset();
        exp_t mid;
        m_sel = 2'd0; m_gain = 16'h8000; m_off = '0;
        p_sel = 2'd0; p_gain = 16'h8000; p_off = '0;
        m_pending = 0; m_imm_due = 0; m_prev = 0; m_clip = 0;
        m_fill = 0; m_dac = 14'h2000;
        mid.val = 14'h2000; mid.clip = 1'b0;
        q.delete();
        q.push_back(mid);
        q.push_back(mid);
    endtask

    // Applies one clock edge to the model using the inputs driven at that edge.
    task automatic model_edge();
        exp_t front;
        bit   wrap, apply;
        wrap  = en && m_prev && !phase_msb;
        apply = m_imm_due || (wrap && m_pending);
        if (en) begin
            q.push_back(calc(m_sel, m_gain, m_off, sine_din, ramp_din, phase_msb));
            front  = q.pop_front();
            m_dac  = front.val;
            m_clip = front.clip || (m_clip && !clip_clr);
            m_prev = phase_msb;
            if (m_fill < 3) m_fill++;
        end else begin
            m_clip = m_clip && !clip_clr;
        end
        if (apply) begin
            m_sel = p_sel; m_gain = p_gain; m_off = p_off;
        end
        if (cfg_wr) begin
            p_sel = cfg_wave_sel; p_gain = cfg_gain; p_off = cfg_offset;
            m_pending = 1; m_imm_due = cfg_imm;
        end else if (apply) begin
            m_pending = 0; m_imm_due = 0;
        end
    endtask

    task automatic step(input logic e, input logic [DW-1:0] s, input logic m);
        en = e; sine_din = s; ramp_din = ~s; phase_msb = m;
        @(posedge clk);
        model_edge();
        #1;
        cfg_wr = 1'b0; cfg_imm = 1'b0; clip_clr = 1'b0;
    endtask

    task automatic set_cfg(input logic imm, input logic [1:0] sel,
                           input logic [GW-1:0] g, input logic [DW-1:0] off);
        cfg_wr = 1'b1; cfg_imm = imm; cfg_wave_sel = sel; cfg_gain = g; cfg_offset = off;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 0; cfg_wr = 0; cfg_imm = 0; clip_clr = 0;
        sine_din = '0; ramp_din = '0; phase_msb = 0;
        cfg_wave_sel = 2'd0; cfg_gain = 16'h8000; cfg_offset = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (dac_dout !== 14'h2000) begin errors++; $display("FAIL reset_dac: got %h exp 2000", dac_dout); end
        checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b exp 0", cfg_pending); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", dout_valid); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 14'h3FFF, 1'b0);
            checks++; if (dac_dout !== m_dac) begin errors++; $display("FAIL fill_dac[%0d]: got %h exp %h", i, dac_dout, m_dac); end
            checks++; if (dout_valid !== (m_fill == 3)) begin errors++; $display("FAIL fill_valid[%0d]: got %b exp %b", i, dout_valid, m_fill == 3); end
        end
        checks++; if (dac_dout !== 14'h3FFF) begin errors++; $display("FAIL fill_final: got %h exp 3fff", dac_dout); end
    endtask

    task automatic test_imm_gain();
        set_cfg(1'b1, 2'd0, 16'h4000, 14'h0000);
        step(1'b0, 14'h0000, 1'b0);
        checks++; if (cfg_pending !== 1'b1) begin errors++; $display("FAIL imm_pending_set: got %b exp 1", cfg_pending); end
        step(1'b0, 14'h0000, 1'b0);
        checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL imm_pending_clr: got %b exp 0", cfg_pending); end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 14'h0000, 1'b0);
            checks++; if (dac_dout !== m_dac) begin errors++; $display("FAIL imm_dac[%0d]: got %h exp %h", i, dac_dout, m_dac); end
        end
        checks++; if (dac_dout !== 14'h1000) begin errors++; $display("FAIL imm_final: got %h exp 1000", dac_dout); end
    endtask

    task automatic test_saturation();
        set_cfg(1'b1, 2'd0, 16'hFFFF, 14'h0000);
        step(1'b0, 14'h3FFF, 1'b0);
        step(1'b0, 14'h3FFF, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 14'h3FFF, 1'b0);
        checks++; if (dac_dout !== 14'h3FFF || dac_dout !== m_dac) begin errors++; $display("FAIL sat_hi: got %h exp 3fff", dac_dout); end
`ifdef WAVE_SCALER_CLIP_FLAG_EN
        checks++; if (clip_sticky !== 1'b1) begin errors++; $display("FAIL clip_set: got %b exp 1", clip_sticky); end
        clip_clr = 1'b1;
        step(1'b0, 14'h3FFF, 1'b0);
        checks++; if (clip_sticky !== m_clip || clip_sticky !== 1'b0) begin errors++; $display("FAIL clip_clr: got %b exp 0", clip_sticky); end
`endif
        set_cfg(1'b1, 2'd0, 16'h8000, 14'h2000);
        step(1'b0, 14'h0000, 1'b0);
        step(1'b0, 14'h0000, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 14'h0000, 1'b0);
        checks++; if (dac_dout !== 14'h0000 || dac_dout !== m_dac) begin errors++; $display("FAIL sat_lo: got %h exp 0000", dac_dout); end
    endtask

    task automatic test_dc_square();
        set_cfg(1'b1, 2'd3, 16'h8000, 14'd100);
        step(1'b0, 14'h0000, 1'b0);
        step(1'b0, 14'h0000, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, DW'($urandom_range(0, 16383)), 1'b0);
        checks++; if (dac_dout !== 14'h2064 || dac_dout !== m_dac) begin errors++; $display("FAIL dc: got %h exp 2064", dac_dout); end
        set_cfg(1'b1, 2'd2, 16'h8000, 14'h0000);
        step(1'b0, 14'h0000, 1'b0);
        step(1'b0, 14'h0000, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, DW'($urandom_range(0, 16383)), (i % 4) < 2);
            checks++; if (dac_dout !== m_dac) begin errors++; $display("FAIL square[%0d]: got %h exp %h", i, dac_dout, m_dac); end
        end
        // ramp path with the same stream
        set_cfg(1'b1, 2'd1, 16'h6000, 14'h3F00);
        step(1'b0, 14'h0000, 1'b0);
        step(1'b0, 14'h0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, DW'($urandom_range(0, 16383)), 1'b0);
            checks++; if (dac_dout !== m_dac) begin errors++; $display("FAIL ramp[%0d]: got %h exp %h", i, dac_dout, m_dac); end
        end
    endtask

    task automatic test_deferred();
        set_cfg(1'b1, 2'd0, 16'h8000, 14'h0000);
        step(1'b0, 14'h0000, 1'b1);
        step(1'b0, 14'h0000, 1'b1);
        step(1'b1, 14'h1234, 1'b1);
        set_cfg(1'b0, 2'd0, 16'h4000, 14'h0000);
        step(1'b1, 14'h0000, 1'b1);
        step(1'b1, 14'h0000, 1'b1);
        checks++; if (cfg_pending !== 1'b1) begin errors++; $display("FAIL defer_hold: got %b exp 1", cfg_pending); end
        checks++; if (dac_dout !== m_dac) begin errors++; $display("FAIL defer_unchanged: got %h exp %h", dac_dout, m_dac); end
        step(1'b1, 14'h0000, 1'b0);
        checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL defer_wrap_clr: got %b exp 0", cfg_pending); end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 14'h0000, 1'b0);
            checks++; if (dac_dout !== m_dac) begin errors++; $display("FAIL defer_dac[%0d]: got %h exp %h", i, dac_dout, m_dac); end
        end
        checks++; if (dac_dout !== 14'h1000) begin errors++; $display("FAIL defer_final: got %h exp 1000", dac_dout); end
        // second write landing on the wrap edge keeps pending set
        step(1'b1, 14'h0000, 1'b1);
        set_cfg(1'b0, 2'd0, 16'h8000, 14'h0000);
        step(1'b1, 14'h0000, 1'b1);
        set_cfg(1'b0, 2'd0, 16'h2000, 14'h0000);
        step(1'b1, 14'h0000, 1'b0);
        checks++; if (cfg_pending !== 1'b1 || m_pending != 1) begin errors++; $display("FAIL wrap_rewrite: got %b exp 1", cfg_pending); end
        step(1'b1, 14'h0000, 1'b1);
        step(1'b1, 14'h0000, 1'b0);
        checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL wrap_rewrite_apply: got %b exp 0", cfg_pending); end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 14'h0000, 1'b0);
            checks++; if (dac_dout !== m_dac) begin errors++; $display("FAIL rewrite_dac[%0d]: got %h exp %h", i, dac_dout, m_dac); end
        end
        checks++; if (dac_dout !== 14'h1800) begin errors++; $display("FAIL rewrite_final: got %h exp 1800", dac_dout); end
        // immediate apply completes, then a deferred write waits for a wrap
        set_cfg(1'b1, 2'd0, 16'h8000, 14'h0000);
        step(1'b0, 14'h0000, 1'b0);
        set_cfg(1'b0, 2'd3, 16'h8000, 14'h0010);
        step(1'b0, 14'h0000, 1'b0);
        checks++; if (cfg_pending !== 1'b1) begin errors++; $display("FAIL imm_then_defer: got %b exp 1", cfg_pending); end
        for (int i = 0; i < 6; i++) begin
            step(1'b1, DW'($urandom_range(0, 16383)), i < 2);
            checks++; if (dac_dout !== m_dac) begin errors++; $display("FAIL imm_defer_dac[%0d]: got %h exp %h", i, dac_dout, m_dac); end
        end
    endtask

    task automatic test_en_hold();
        logic [DW-1:0] held;
        set_cfg(1'b1, 2'd0, 16'hA000, 14'h3FF0);
        step(1'b0, 14'h0000, 1'b0);
        step(1'b0, 14'h0000, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, DW'($urandom_range(0, 16383)), 1'b0);
        held = m_dac;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, DW'($urandom_range(0, 16383)), i[0]);
            checks++; if (dac_dout !== held) begin errors++; $display("FAIL hold[%0d]: got %h exp %h", i, dac_dout, held); end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, DW'($urandom_range(0, 16383)), 1'b0);
            checks++; if (dac_dout !== m_dac) begin errors++; $display("FAIL resume[%0d]: got %h exp %h", i, dac_dout, m_dac); end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 14'h0100, 1'b1);
        set_cfg(1'b0, 2'd3, 16'h2000, 14'h0123);
        step(1'b1, 14'h0200, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (dac_dout !== 14'h2000) begin errors++; $display("FAIL rstmid_dac: got %h exp 2000", dac_dout); end
        checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL rstmid_pending: got %b exp 0", cfg_pending); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b exp 0", dout_valid); end
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 14'h3FFF, 1'b0);
            checks++; if (dac_dout !== m_dac || cfg_pending !== 1'b0) begin errors++; $display("FAIL rstmid_after[%0d]: got %h/%b exp %h/0", i, dac_dout, cfg_pending, m_dac); end
        end
        checks++; if (dac_dout !== 14'h3FFF || dout_valid !== 1'b1) begin errors++; $display("FAIL rstmid_final: got %h/%b exp 3fff/1", dac_dout, dout_valid); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_imm_gain();
        test_saturation();
        test_dc_square();
        test_deferred();
        test_en_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
